alu_vector_driver: RTL

//  Synthesizable initiator for the ALU operand interface (A, B, ALUctr -> ALUResult, Zero).
//  On start, steps through a fixed table of NUM_VEC test vectors and drives each one onto the ALU.

---
 rtl/alu_vec_pkg.sv | 46 ++++
 rtl/alu_vec_rom.sv | 20 ++
 rtl/alu_vector_driver.sv | 133 +++++++++++++
 3 files changed

// File: rtl/alu_vec_pkg.sv
// rtl/alu_vec_pkg.sv - ALU control codes, vector record and default self-check table
package alu_vec_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam int VEC_DATA_W = 32;

  typedef struct packed {
    logic [VEC_DATA_W-1:0] a;
    logic [VEC_DATA_W-1:0] b;
    logic [3:0]            ctr;
    logic [VEC_DATA_W-1:0] exp_res;
    logic                  exp_zero;
  } vec_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  function automatic vec_t default_vec(input logic [3:0] idx);
    vec_t v;
    v = '0;
    case (idx)
      4'd0: v = '{32'h0000_0001, 32'h0000_0002, ALU_ADD, 32'h0000_0003, 1'b0};
      4'd1: v = '{32'h0000_0005, 32'h0000_0005, ALU_SUB, 32'h0000_0000, 1'b1};
      4'd2: v = '{32'hF0F0_F0F0, 32'h0FF0_0FF0, ALU_AND, 32'h00F0_00F0, 1'b0};
      4'd3: v = '{32'hF0F0_F0F0, 32'h0FF0_0FF0, ALU_OR,  32'hFFF0_FFF0, 1'b0};
      4'd4: v = '{32'h0000_0001, 32'h0000_0002, ALU_SLT, 32'h0000_0001, 1'b0};
      4'd5: v = '{32'h0000_0002, 32'h0000_0001, ALU_SLT, 32'h0000_0000, 1'b1};
      // carry out of the add is discarded, so the sum wraps to zero
      4'd6: v = '{32'hFFFF_FFFF, 32'h0000_0001, ALU_ADD, 32'h0000_0000, 1'b1};
      4'd7: v = '{32'h0000_0000, 32'h0000_0001, ALU_SUB, 32'hFFFF_FFFF, 1'b0};
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/alu_vec_rom.sv
// rtl/alu_vec_rom.sv - combinational index to vector lookup; indices past the table read as zero
import alu_vec_pkg::*;

module alu_vec_rom #(
  parameter int NUM_VEC = 8
) (
  input  logic [3:0] i_idx,
  output vec_t       o_vec
);

  localparam logic [4:0] NUM_VEC_L = 5'(NUM_VEC);

  always_comb begin
    o_vec = '0;
    if ({1'b0, i_idx} < NUM_VEC_L) begin
      o_vec = default_vec(i_idx);
    end
  end

endmodule

// File: rtl/alu_vector_driver.sv
// rtl/alu_vector_driver.sv - drives the vector table onto the ALU and tallies matches
import alu_vec_pkg::*;

module alu_vector_driver #(
  parameter int DATA_W  = 32,
  parameter int CTR_W   = 4,
  parameter int NUM_VEC = 8,
  parameter int SETTLE  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [CTR_W-1:0]  alu_ctr,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic [4:0]        pass_cnt,
  output logic [4:0]        fail_cnt,
  output logic              first_fail_valid,
  output logic [3:0]        first_fail_idx
);

  localparam int         SET_W    = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
  localparam logic [3:0] LAST_IDX = 4'(NUM_VEC - 1);

  state_t              r_state;
  logic [3:0]          r_idx;
  logic [SET_W-1:0]    r_settle;
  logic                r_busy;
  logic                r_done;
  logic [DATA_W-1:0]   r_alu_a;
  logic [DATA_W-1:0]   r_alu_b;
  logic [CTR_W-1:0]    r_alu_ctr;
  logic [4:0]          r_pass_cnt;
  logic [4:0]          r_fail_cnt;
  logic                r_ff_valid;
  logic [3:0]          r_ff_idx;

  vec_t                w_vec;
  logic                w_match;

  alu_vec_rom #(.NUM_VEC(NUM_VEC)) u_rom (
    .i_idx (r_idx),
    .o_vec (w_vec)
  );

  // Expected values come straight from the table entry still addressed by r_idx
  assign w_match = (alu_result == DATA_W'(w_vec.exp_res)) && (alu_zero == w_vec.exp_zero);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_settle   <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_ctr  <= '0;
      r_pass_cnt <= '0;
      r_fail_cnt <= '0;
      r_ff_valid <= 1'b0;
      r_ff_idx   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_idx      <= '0;
            r_pass_cnt <= '0;
            r_fail_cnt <= '0;
            r_ff_valid <= 1'b0;
            r_ff_idx   <= '0;
            r_busy     <= 1'b1;
            r_state    <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          r_alu_a   <= DATA_W'(w_vec.a);
          r_alu_b   <= DATA_W'(w_vec.b);
          r_alu_ctr <= CTR_W'(w_vec.ctr);
          r_settle  <= SET_W'(SETTLE);
          r_state   <= (SETTLE > 0) ? S_WAIT : S_CHECK;
        end
        S_WAIT: begin
          r_settle <= r_settle - SET_W'(1);
          if (r_settle == SET_W'(1)) begin
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (w_match) begin
            r_pass_cnt <= r_pass_cnt + 5'd1;
          end else begin
            r_fail_cnt <= r_fail_cnt + 5'd1;
            if (!r_ff_valid) begin
              r_ff_valid <= 1'b1;
              r_ff_idx   <= r_idx;
            end
          end
          if (r_idx == LAST_IDX) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_idx   <= r_idx + 4'd1;
            r_state <= S_DRIVE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy             = r_busy;
  assign done             = r_done;
  assign alu_a            = r_alu_a;
  assign alu_b            = r_alu_b;
  assign alu_ctr          = r_alu_ctr;
  assign pass_cnt         = r_pass_cnt;
  assign fail_cnt         = r_fail_cnt;
  assign first_fail_valid = r_ff_valid;
  assign first_fail_idx   = r_ff_idx;

endmodule
